// File: rtl/arbiter_wrr_pkg.sv
// rtl/arbiter_wrr_pkg.sv - shared types and width helpers for the weighted round-robin arbiter
package arbiter_wrr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits, so a single-port build still has a select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbiter_wrr_if.sv
// rtl/arbiter_wrr_if.sv - request/grant bundle between the masters and the arbiter
interface arbiter_wrr_if
    import arbiter_wrr_pkg::*;
#(
    parameter int NUM_PORTS = 6,
    parameter int WEIGHT_W  = 4,
    localparam int SEL_W    = sel_width(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]          request;
    logic [NUM_PORTS-1:0]          enable;
    logic [NUM_PORTS*WEIGHT_W-1:0] weight;
    logic [NUM_PORTS-1:0]          grant;
    logic [SEL_W-1:0]              select;
    logic                          active;

    modport master (
        output request, enable, weight,
        input  grant, select, active
    );

    modport slave (
        input  request, enable, weight,
        output grant, select, active
    );
endinterface

// File: rtl/arbiter_rr_pick.sv
// rtl/arbiter_rr_pick.sv - combinational round-robin winner search starting at a pointer
module arbiter_rr_pick
    import arbiter_wrr_pkg::*;
#(
    parameter int NUM_PORTS = 6,
    localparam int SEL_W    = sel_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_vec,
    input  logic [SEL_W-1:0]     ptr,
    input  logic [SEL_W-1:0]     excl_idx,
    input  logic                 excl_valid,
    output logic                 found,
    output logic [SEL_W-1:0]     win_idx,
    output logic [NUM_PORTS-1:0] win_onehot
);
    logic [NUM_PORTS-1:0]   masked;
    logic [2*NUM_PORTS-1:0] search;

    // Doubling the vector lets a plain lowest-bit search handle the wrap past the last port.
    always_comb begin
        masked = req_vec;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (excl_valid && (SEL_W'(i) == excl_idx)) begin
                masked[i] = 1'b0;
            end
        end

        search = {masked, masked};
        for (int i = 0; i < 2*NUM_PORTS; i++) begin
            if (i < int'(ptr)) begin
                search[i] = 1'b0;
            end
        end

        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < 2*NUM_PORTS; i++) begin
            if (search[i] && !found) begin
                found   = 1'b1;
                win_idx = (i >= NUM_PORTS) ? SEL_W'(i - NUM_PORTS) : SEL_W'(i);
            end
        end

        win_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (found && (SEL_W'(i) == win_idx)) begin
                win_onehot[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arbiter_wrr.sv
// rtl/arbiter_wrr.sv - weighted round-robin arbiter with ownership hold and quantum preemption
module arbiter_wrr
    import arbiter_wrr_pkg::*;
#(
    parameter int NUM_PORTS = 6,
    parameter int WEIGHT_W  = 4,
    localparam int SEL_W    = sel_width(NUM_PORTS)
) (
    input  logic          clk,
    input  logic          rst,
    arbiter_wrr_if.slave  bus
);
    arb_state_t           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]     select_q, select_d;
    logic                 active_q, active_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]  credit_q, credit_d;

    logic [NUM_PORTS-1:0] elig;
    logic                 pick_found;
    logic [SEL_W-1:0]     pick_idx;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic                 owner_req;
    logic [WEIGHT_W-1:0]  owner_weight;
    logic [WEIGHT_W-1:0]  pick_weight;
    logic                 take_new;

    assign elig = bus.request & bus.enable;

    // While owned, the owner is excluded so the pick is always "somebody else".
    arbiter_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_vec    (elig),
        .ptr        (ptr_q),
        .excl_idx   (select_q),
        .excl_valid (state_q == ST_OWNED),
        .found      (pick_found),
        .win_idx    (pick_idx),
        .win_onehot (pick_onehot)
    );

    always_comb begin
        owner_req    = 1'b0;
        owner_weight = '0;
        pick_weight  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (SEL_W'(i) == select_q) begin
                owner_req    = bus.request[i];
                owner_weight = bus.weight[i*WEIGHT_W +: WEIGHT_W];
            end
            if (SEL_W'(i) == pick_idx) begin
                pick_weight = bus.weight[i*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    // A zero credit means the quantum was loaded as unlimited, so later weight edits cannot preempt mid-hold.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        active_d = active_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        take_new = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take_new = pick_found;
            end
            ST_OWNED: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        take_new = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        select_d = '0;
                        active_d = 1'b0;
                        credit_d = '0;
                    end
                end else if (credit_q == WEIGHT_W'(1)) begin
                    if (pick_found) begin
                        take_new = 1'b1;
                    end else begin
                        credit_d = owner_weight;
                    end
                end else if (credit_q != '0) begin
                    credit_d = credit_q - WEIGHT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_new) begin
            state_d  = ST_OWNED;
            grant_d  = pick_onehot;
            select_d = pick_idx;
            active_d = 1'b1;
            credit_d = pick_weight;
            ptr_d    = (pick_idx == SEL_W'(NUM_PORTS - 1)) ? '0 : pick_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            select_q <= '0;
            active_q <= 1'b0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            active_q <= active_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.select = select_q;
    assign bus.active = active_q;
endmodule

// File: doc/arbiter_wrr.md
Name: arbiter_wrr

Overview:
- Parametrised, weighted round-robin bus arbiter for the Wishbone interconnect; next generation of the single-cycle token arbiter.
- Adds ownership hold: a granted master keeps the bus while its request stays high.
- Adds a per-port programmable quantum that preempts a holding master only when others are waiting.
- Adds zero-bubble handover and a per-port enable mask.

Parameters:
- NUM_PORTS, 6, number of requesting masters (>=1).
- WEIGHT_W, 4, width of each per-port quantum field.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- request  in  NUM_PORTS  per-master bus request; held high for the whole bus cycle.
- enable  in  NUM_PORTS  per-port enable; a disabled port is never newly granted.
- weight  in  NUM_PORTS*WEIGHT_W  quantum of port i at weight[i*WEIGHT_W +: WEIGHT_W], in cycles; 0 means unlimited (no preemption).
- grant  out  NUM_PORTS  one-hot ownership; registered.
- select  out  max(clog2(NUM_PORTS),1)  binary index of granted port; 0 when idle.
- active  out  1  high whenever grant is nonzero.

Behaviour:
- Eligible vector: elig = request & enable.
- All outputs are registered. Reset values: grant=0, select=0, active=0, state=IDLE, credit=0, pointer=0 (search starts at port 0).
- Round-robin pick:
  - Search begins at port pointer and wraps modulo NUM_PORTS.
  - The first eligible port wins.
  - On every new grant to port k, pointer <= (k+1) mod NUM_PORTS.
- IDLE:
  - If elig != 0 at an edge: grant the winner at that edge (1-cycle latency from request sampled high to grant high).
  - On grant, load credit <= weight[k] and go to OWNED.
  - Otherwise outputs stay 0.
- OWNED (owner k):
  - Release: if request[k]==0 at an edge, drop k at that edge.
    - If elig without k is nonzero, grant the next winner at the same edge (no idle cycle) and stay OWNED.
    - Otherwise go to IDLE with grant=0 and active=0.
  - Preempt: if request[k]==1, credit==1, and elig excluding k is nonzero, hand over to the next winner at that edge. Port k may re-win later in round-robin order.
  - Uncontended expiry: if credit==1 and no other eligible port, k keeps the grant and credit reloads to weight[k].
  - Otherwise, if weight[k]!=0, credit decrements by 1 per cycle held. With weight[k]==0, credit is not used and k is never preempted.
  - Result: under contention, port k holds the grant for exactly weight[k] consecutive cycles (weight 0 = until release).
- Enable deasserted for the current owner does not revoke its grant; it only blocks future grants.
- Weight changes take effect at the next credit load (grant or reload), never mid-quantum.
- Simultaneous release by the owner and new requests: the new requests participate in the same-edge pick.
- NUM_PORTS=1: pointer is constant 0, select is 1 bit fixed at 0; hold and release behaviour still applies.
- rst asserted mid-ownership: the next edge forces all reset values, regardless of request.
- Invariants:
  - grant is always one-hot or zero.
  - active == |grant.
  - select == index(grant).

Decomposition:
- Shared header (existing verilog_utils.vh): clog2 function; add a max(…,1) width helper for select.
- State encoding constants (IDLE, OWNED) are local parameters of this block.
- One sub-module: arbiter_rr_pick. It is combinational and takes (req vector, pointer, exclude index/valid) and returns (found, winner index, winner one-hot). It uses a double-width masked priority search.
- The top level holds the state, credit counter, pointer and output registers.

Test Plan (NUM_PORTS=4, WEIGHT_W=4):
- Reset then request=0001, weight all 0 -> grant=0001, select=0, active=1 one cycle later; held while request stays high; after request=0000, grant=0000 one edge later.
- request=1111 held, all weights=2 -> grants cycle 0001,0001,0010,0010,0100,0100,1000,1000,0001…, with no idle cycle between owners.
- Owner port 1 (weight 0) holds for 20 cycles while port 3 requests -> port 1 is never preempted. Port 1 releases -> grant=1000 on the same edge, active stays 1.
- Only port 2 requesting, weight[2]=3, for 10 cycles -> grant stays 0100 throughout; credit reloads with no gap.
- enable=1101, request=0011 -> only port 0 is granted. Clearing enable[0] mid-ownership keeps grant=0001 until port 0 releases, then active=0.
- rst pulsed while port 2 is granted -> next edge grant=0, select=0, active=0. After rst releases with request=1111, the first grant is 0001.
